// File: rtl/inst_mem_sync.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_sync
// Brief    : Writable instruction memory with a synchronous one-cycle read,
//            request/valid fetch handshake, a load port for run-time program
//            writes, and a post-reset clear sequencer that fills every word
//            with NOP before fetches are accepted.
// Options  : INST_MEM_FETCH_CNT_EN adds output fetch_cnt, a 16-bit wrapping
//            count of fetches accepted since reset.
// Revision : 1.0 - initial release
// ============================================================================
module inst_mem_sync #(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 4,
  parameter int              PC_W     = 16,
  parameter logic [DATA_W-1:0] NOP_INST = 16'b00001_000_0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [PC_W-1:0]   pc,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic              ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack
`ifdef INST_MEM_FETCH_CNT_EN
  ,
  output logic [15:0]       fetch_cnt
`endif
);

  localparam int c_DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] c_LAST = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [DATA_W-1:0]   r_mem [c_DEPTH];
  logic                r_inst_valid;
  logic [DATA_W-1:0]   r_inst;
  logic                r_ready;
  logic                r_wr_ack;

  // Only the low pc bits address the array; upper bits wrap around.
  logic [ADDR_W-1:0]   w_addr;
  logic                w_fetch;
  logic                w_write;
  logic                w_bypass;
  logic                w_pc_unused;

  assign w_addr      = pc[ADDR_W-1:0];
  assign w_pc_unused = ^pc[PC_W-1:ADDR_W];
  assign w_fetch     = (r_state == S_RUN) && fetch_req;
  assign w_write     = (r_state == S_RUN) && wr_en;
  // A same-cycle write to the fetched word wins, so the fetch sees new data.
  assign w_bypass    = w_write && (wr_addr == w_addr);

  // Memory array: NOP fill while clearing, load-port writes while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_clr_cnt] <= NOP_INST;
      end else if (w_write) begin
        r_mem[wr_addr] <= wr_data;
      end
    end
  end

  // Clear/run sequencer together with the registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_CLEAR;
      r_clr_cnt    <= '0;
      r_ready      <= 1'b0;
      r_inst_valid <= 1'b0;
      r_wr_ack     <= 1'b0;
      r_inst       <= NOP_INST;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_inst_valid <= 1'b0;
          r_wr_ack     <= 1'b0;
          r_clr_cnt    <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == c_LAST) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
          end
        end
        S_RUN: begin
          r_ready      <= 1'b1;
          r_inst_valid <= w_fetch;
          r_wr_ack     <= w_write;
          if (w_fetch) begin
            r_inst <= w_bypass ? wr_data : r_mem[w_addr];
          end
        end
        default: begin
          r_state <= S_CLEAR;
        end
      endcase
    end
  end

  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign ready      = r_ready;
  assign wr_ack     = r_wr_ack;

`ifdef INST_MEM_FETCH_CNT_EN
  logic [15:0] r_fetch_cnt;

  // Count accepted fetches; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_cnt <= '0;
    end else if (w_fetch) begin
      r_fetch_cnt <= r_fetch_cnt + 16'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_mem_sync
// Brief    : Directed self-checking bench for inst_mem_sync. A behavioural
//            model tracks the expected outputs; a compare process checks them
//            every cycle, and literal checks pin key results.
// Options  : INST_MEM_FETCH_CNT_EN also checks fetch_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_mem_sync;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [15:0] pc;
  logic        inst_valid;
  logic [15:0] inst;
  logic        ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
`ifdef INST_MEM_FETCH_CNT_EN
  logic [15:0] fetch_cnt;
`endif

  int vectors   = 0;
  int miscompares = 0;

  inst_mem_sync dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .pc         (pc),
    .inst_valid (inst_valid),
    .inst       (inst),
    .ready      (ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack)
`ifdef INST_MEM_FETCH_CNT_EN
    ,
    .fetch_cnt  (fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          m_known = 0;
  int          m_clear_left;
  logic [15:0] m_mem [16];
  logic        m_ready, m_valid, m_ack;
  logic [15:0] m_inst;
  int          m_cnt;

  always @(posedge clk) begin
    if (rst === 1'b0) begin
      m_known      = 1;
      m_clear_left = 16;
      m_ready      = 0;
      m_valid      = 0;
      m_ack        = 0;
      m_inst       = NOP;
      m_cnt        = 0;
    end else if (m_known) begin
      if (m_clear_left > 0) begin
        m_clear_left = m_clear_left - 1;
        m_valid = 0;
        m_ack   = 0;
        if (m_clear_left == 0) begin
          m_ready = 1;
          for (int k = 0; k < 16; k++) m_mem[k] = NOP;
        end
      end else begin
        if (wr_en) m_mem[wr_addr] = wr_data;
        m_ack   = wr_en;
        m_valid = fetch_req;
        if (fetch_req) begin
          m_inst = m_mem[pc % 16];
          m_cnt  = (m_cnt + 1) % 65536;
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs are sampled on the falling edge.
  always @(negedge clk) begin
    if (m_known) begin
      check("ready",      {15'd0, ready},      {15'd0, m_ready});
      check("inst_valid", {15'd0, inst_valid}, {15'd0, m_valid});
      check("wr_ack",     {15'd0, wr_ack},     {15'd0, m_ack});
      check("inst",       inst,                m_inst);
`ifdef INST_MEM_FETCH_CNT_EN
      check("fetch_cnt",  fetch_cnt,           m_cnt[15:0]);
`endif
    end
  end

  // One clock cycle with the given inputs; returns after the falling edge.
  task automatic cyc(input logic fr, input logic [15:0] p,
                     input logic we, input logic [3:0] wa, input logic [15:0] wd);
    fetch_req = fr; pc = p; wr_en = we; wr_addr = wa; wr_data = wd;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 16'h0, 0, 4'h0, 16'h0);
  endtask

  initial begin
    rst = 1'b0; fetch_req = 0; pc = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    @(negedge clk);
    idle(2);
    check("reset_ready", {15'd0, ready}, 16'd0);
    check("reset_inst",  inst, 16'h0800);
`ifdef INST_MEM_FETCH_CNT_EN
    check("reset_cnt", fetch_cnt, 16'd0);
`endif
    // Clear phase: writes and fetches must be ignored; ready rises on edge 16.
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc(1, 16'(i), 1, 4'(i), 16'hBEEF);
      check("clear_ready", {15'd0, ready}, (i == 15) ? 16'd1 : 16'd0);
      check("clear_ack",   {15'd0, wr_ack}, 16'd0);
    end
    // Every word reads back as NOP.
    for (int i = 0; i < 16; i++) begin
      cyc(1, 16'(i), 0, 4'h0, 16'h0);
      check("nop_fill", inst, 16'h0800);
    end
    idle(1);
    // Load three words, then fetch them back-to-back.
    cyc(0, 0, 1, 4'd1, 16'h6801);
    check("ack1", {15'd0, wr_ack}, 16'd1);
    cyc(0, 0, 1, 4'd2, 16'h6902);
    cyc(0, 0, 1, 4'd3, 16'h9820);
    cyc(1, 16'd1, 0, 0, 0);
    check("ack_drop", {15'd0, wr_ack}, 16'd0);
    check("rd1", inst, 16'h6801);
    cyc(1, 16'd2, 0, 0, 0);
    check("rd2", inst, 16'h6902);
    cyc(1, 16'd3, 0, 0, 0);
    check("rd3", inst, 16'h9820);
    check("rd3_valid", {15'd0, inst_valid}, 16'd1);
    idle(1);
    check("hold_inst", inst, 16'h9820);
    // Write-first bypass on the same address.
    cyc(1, 16'd5, 1, 4'd5, 16'hD900);
    check("bypass", inst, 16'hD900);
    cyc(1, 16'd5, 0, 0, 0);
    check("bypass_rep", inst, 16'hD900);
    // Same-cycle write and fetch on different addresses.
    cyc(1, 16'd2, 1, 4'd7, 16'h1234);
    check("diff_rd", inst, 16'h6902);
    cyc(1, 16'd7, 0, 0, 0);
    check("diff_wr", inst, 16'h1234);
    // Address wrap.
    cyc(0, 0, 1, 4'd3, 16'hABCD);
    cyc(1, 16'h0013, 0, 0, 0);
    check("wrap", inst, 16'hABCD);
    cyc(1, 16'hFFF1, 0, 0, 0);
    check("wrap_hi", inst, 16'h6801);
    // Reset during the third cycle of a fetch burst.
    cyc(1, 16'd1, 0, 0, 0);
    cyc(1, 16'd2, 0, 0, 0);
    rst = 1'b0;
    cyc(1, 16'd3, 0, 0, 0);
    check("midrst_valid", {15'd0, inst_valid}, 16'd0);
    check("midrst_ready", {15'd0, ready}, 16'd0);
    rst = 1'b1;
    idle(15);
    check("reclr_notready", {15'd0, ready}, 16'd0);
    idle(1);
    check("reclr_ready", {15'd0, ready}, 16'd1);
    cyc(1, 16'd1, 0, 0, 0);
    check("reclr_word1", inst, 16'h0800);
    // Twenty fetches since the reset above: one already done, nineteen more.
    for (int i = 0; i < 19; i++) cyc(1, 16'(i + 3), 0, 0, 0);
`ifdef INST_MEM_FETCH_CNT_EN
    check("cnt20", fetch_cnt, 16'd20);
`endif
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
